// File: rtl/seg7_pkg.sv
// Shared types and segment lookup table for the 7-segment display controller.
package seg7_pkg;

  localparam int SEG7_DIGITS = 8;
  localparam int SEG7_IDX_W  = $clog2(SEG7_DIGITS);

  // Active-low {dp,g,f,e,d,c,b,a}
  typedef logic [7:0] seg7_pat_t;

  // Active-low {g,f,e,d,c,b,a} for hex digits 0..F
  localparam logic [6:0] HEX2SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam seg7_pat_t SEG7_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble + decimal point to active-low cathode pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp_on,
  output seg7_pat_t  o_pat
);

  assign o_pat = {~i_dp_on, HEX2SEG[i_nibble]};

endmodule

// File: rtl/seg7_disp_ctrl.sv
// 8-digit multiplexed common-anode 7-segment driver with per-frame snapshot and
// anti-ghosting guard. Define SEG7_DIM_EN to add brightness_i PWM dimming.
module seg7_disp_ctrl
  import seg7_pkg::*;
#(
  parameter int         DIGIT_TICKS = 50000,
  parameter int         GUARD_TICKS = 16,
  parameter logic [7:0] DP_MASK     = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] disp_data_i,
  input  logic        disp_en_i,
  output logic [7:0]  seg_cathode_o,
  output logic [7:0]  seg_anode_o
`ifdef SEG7_DIM_EN
  ,
  input  logic [3:0]  brightness_i
`endif
);

  localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] GUARD_END = TW'(GUARD_TICKS);

  logic [TW-1:0]         r_tick_cnt;
  logic [SEG7_IDX_W-1:0] r_digit_idx;
  logic [31:0]           r_shadow;
  logic [7:0]            r_anode;
  seg7_pat_t             r_cathode;

  logic       w_slot_end;
  logic       w_frame_end;
  logic       w_lit;
  logic [3:0] w_nibble;
  seg7_pat_t  w_pat;

  assign w_slot_end  = (r_tick_cnt == TICK_LAST);
  assign w_frame_end = w_slot_end && (r_digit_idx == SEG7_IDX_W'(SEG7_DIGITS - 1));
  assign w_nibble    = r_shadow[{r_digit_idx, 2'b00} +: 4];

`ifdef SEG7_DIM_EN
  logic [3:0] r_pwm_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_pwm_cnt <= 4'd0;
    else        r_pwm_cnt <= r_pwm_cnt + 4'd1;
  end

  assign w_lit = disp_en_i && (r_tick_cnt >= GUARD_END) && (r_pwm_cnt <= brightness_i);
`else
  assign w_lit = disp_en_i && (r_tick_cnt >= GUARD_END);
`endif

  seg7_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .i_dp_on  (DP_MASK[r_digit_idx]),
    .o_pat    (w_pat)
  );

  // Snapshot on the last tick of digit 7 so a whole frame shows one word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick_cnt  <= '0;
      r_digit_idx <= '0;
      r_shadow    <= 32'h0;
      r_anode     <= 8'hFF;
      r_cathode   <= SEG7_BLANK;
    end else begin
      r_tick_cnt <= w_slot_end ? '0 : r_tick_cnt + 1'b1;
      if (w_slot_end)  r_digit_idx <= r_digit_idx + 1'b1;
      if (w_frame_end) r_shadow    <= disp_data_i;
      if (w_lit) begin
        r_anode   <= ~(8'h01 << r_digit_idx);
        r_cathode <= w_pat;
      end else begin
        r_anode   <= 8'hFF;
        r_cathode <= SEG7_BLANK;
      end
    end
  end

  assign seg_anode_o   = r_anode;
  assign seg_cathode_o = r_cathode;

endmodule
